// File: rtl/prog_loader.sv
// prog_loader: writable 16-entry instruction store with its loader FSM.
// A host streams {func,value} words over valid/ready. They are written at
// consecutive addresses, the remainder of the store is padded with NOPs,
// and then cpu_run is raised so the CPU can fetch through the read port.
module prog_loader #(
   parameter int ADDR_W = 4,
   parameter int VAL_W  = 4,
   parameter int FUNC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FUNC_W-1:0] in_func,
   input  logic [VAL_W-1:0]  in_val,
   input  logic              in_last,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [VAL_W-1:0]  rd_val,
   output logic [FUNC_W-1:0] rd_func,
   output logic              cpu_run,
   output logic [ADDR_W:0]   load_count,
   output logic              load_err
);

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int WORD_W = FUNC_W + VAL_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FILL = 2'd2,
      RUN  = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W:0]     count_reg, count_next;
   logic                err_reg, err_next;

   logic                wr_en;
   logic [WORD_W-1:0]   wr_data;
   logic [DEPTH-1:0]    entry_we;
   logic [WORD_W-1:0]   mem_reg [DEPTH];
   logic [WORD_W-1:0]   rd_word;

   // Next-state, write strobe and handshake outputs for the loader FSM.
   always_comb begin
      state_next  = state_reg;
      wr_ptr_next = wr_ptr_reg;
      count_next  = count_reg;
      err_next    = err_reg;
      wr_en       = 1'b0;
      wr_data     = '0;
      in_ready    = 1'b0;
      cpu_run     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (load_start) begin
               state_next  = LOAD;
               wr_ptr_next = '0;
               count_next  = '0;
               err_next    = 1'b0;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_en       = 1'b1;
               wr_data     = {in_func, in_val};
               wr_ptr_next = wr_ptr_reg + 1'b1;
               count_next  = count_reg + 1'b1;
               // The 16th word always ends the load; a missing in_last there
               // is flagged rather than silently accepted.
               if (wr_ptr_reg == LAST_ADDR) begin
                  state_next = RUN;
                  err_next   = ~in_last;
               end else if (in_last) begin
                  state_next = FILL;
               end
            end
         end
         FILL: begin
            // Pad with NOPs (all-zero words) up to the top of the store.
            wr_en       = 1'b1;
            wr_data     = '0;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (wr_ptr_reg == LAST_ADDR) begin
               state_next = RUN;
            end
         end
         RUN: begin
            cpu_run = 1'b1;
            if (load_start) begin
               state_next  = LOAD;
               wr_ptr_next = '0;
               count_next  = '0;
               err_next    = 1'b0;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM state, write pointer, word counter and sticky error register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         wr_ptr_reg <= wr_ptr_next;
         count_reg  <= count_next;
         err_reg    <= err_next;
      end
   end

   // One-hot write-enable decode, one bit per store entry.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
         assign entry_we[gi] = wr_en && (wr_ptr_reg == ADDR_W'(gi));
      end
   endgenerate

   // Store array; reset clears every entry so a discarded load leaves no residue.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst) begin
            mem_reg[i] <= '0;
         end else if (entry_we[i]) begin
            mem_reg[i] <= wr_data;
         end
      end
   end

   // Combinational fetch; the CPU sees NOPs until the store is complete.
   assign rd_word = mem_reg[rd_addr];
   assign rd_func = cpu_run ? rd_word[WORD_W-1:VAL_W] : '0;
   assign rd_val  = cpu_run ? rd_word[VAL_W-1:0]      : '0;

   assign load_count = count_reg;
   assign load_err   = err_reg;

endmodule
